// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
// The HALT state is only used when FETCH_HALT_EN is defined.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_C    = 32'h0000_0004;
    localparam logic [31:0] NOP_INST_C    = 32'h0000_0033;
    localparam logic [31:0] EBREAK_INST_C = 32'h0010_0073;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Bubble insertion takes priority over hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INST = NOP_INST_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (bubble_i) begin
            pc_d    = '0;
            pc4_d   = '0;
            inst_d  = BUBBLE_INST;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            pc_d    = pc_i;
            pc4_d   = pc_i + 32'd4;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= BUBBLE_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
    assign inst_o     = inst_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch counter and IF/ID register control.
// Define FETCH_HALT_EN to add the EBREAK halt FSM and the halted port.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_C,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
`ifdef FETCH_HALT_EN
    ,
    output logic        halted
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        ifid_hold;
    logic        ifid_bubble;
    logic        halt_active;

`ifdef FETCH_HALT_EN
    fetch_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    assign halt_active = (state_q == ST_HALT);
    assign halted      = halt_active;
`else
    assign halt_active = 1'b0;
`endif

    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
`ifdef FETCH_HALT_EN
        state_d     = state_q;
`endif
        if (redirect) begin
            // Redirect wins over stall and also cancels a wrong-path halt.
            pc_d        = {redirect_target[31:2], 2'b00};
            ifid_bubble = 1'b1;
`ifdef FETCH_HALT_EN
            state_d     = ST_RUN;
`endif
        end else if (halt_active) begin
            ifid_bubble = 1'b1;
        end else if (stall) begin
            ifid_hold   = 1'b1;
        end else begin
            pc_d    = pc_q + 32'd4;
            count_d = count_q + 32'd1;
`ifdef FETCH_HALT_EN
            if (imem_data == EBREAK_INST_C) state_d = ST_HALT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .BUBBLE_INST(NOP_INST)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst),
        .hold_i    (ifid_hold),
        .bubble_i  (ifid_bubble),
        .pc_i      (pc_q),
        .inst_i    (imem_data),
        .pc_o      (if_id_pc),
        .pc_plus4_o(if_id_pc_plus4),
        .inst_o    (if_id_inst),
        .valid_o   (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then random
// stall/redirect traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0033;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;

    logic [31:0] imem_addr, imem_data, if_id_pc, if_id_pc_plus4, if_id_inst, fetch_count;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] w_addr, w_data, w_pc, w_pc4, w_inst, w_cnt;
    logic        w_valid;
    logic        w_halted;

    logic [31:0] mem [64];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
    logic        m_valid, m_halt;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:2]];
    assign w_data    = mem[w_addr[7:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_inst     (if_id_inst),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
`ifdef FETCH_HALT_EN
        ,
        .halted         (halted)
`endif
    );

    fetch_stage #(
        .RESET_PC(32'hFFFF_FFF8)
    ) dut_w (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .redirect       (1'b0),
        .redirect_target(32'h0),
        .imem_addr      (w_addr),
        .imem_data      (w_data),
        .if_id_pc       (w_pc),
        .if_id_pc_plus4 (w_pc4),
        .if_id_inst     (w_inst),
        .if_id_valid    (w_valid),
        .fetch_count    (w_cnt)
`ifdef FETCH_HALT_EN
        ,
        .halted         (w_halted)
`endif
    );

`ifndef FETCH_HALT_EN
    assign halted   = 1'b0;
    assign w_halted = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h4; m_ipc = '0; m_ipc4 = '0; m_inst = NOP;
        m_valid = 1'b0; m_cnt = '0; m_halt = 1'b0;
    endtask

    task automatic model_bubble();
        m_ipc = '0; m_ipc4 = '0; m_inst = NOP; m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
        logic [31:0] word;
        word = mem[m_pc[7:2]];
        if (rd) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            model_bubble();
            m_halt = 1'b0;
        end else if (m_halt) begin
            model_bubble();
        end else if (!st) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = word; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
`ifdef FETCH_HALT_EN
            m_halt = (word == EBREAK);
`endif
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
        chk("if_id_inst", if_id_inst, m_inst);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("fetch_count", fetch_count, m_cnt);
`ifdef FETCH_HALT_EN
        chk("halted", {31'b0, halted}, {31'b0, m_halt});
`endif
    endtask

    // Called at a negedge: drive inputs, advance model, check after the posedge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        stall = st; redirect = rd; redirect_target = tgt;
        model_edge(st, rd, tgt);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        stall = 1'b0; redirect = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = NOP;
        mem[1] = 32'h0000_2083;  // lw x1,0(x0)
        mem[2] = 32'h0040_2103;  // lw x2,4(x0)
        mem[3] = 32'h0080_2183;  // lw x3,8(x0)
        mem[4] = 32'h0020_e233;  // or x4,x1,x2
        mem[7] = EBREAK;
        for (int i = 8; i < 64; i++) if (mem[i] == EBREAK) mem[i] = NOP;
        for (int i = 5; i < 7; i++)  if (mem[i] == EBREAK) mem[i] = NOP;

        // Reset state
        model_reset();
        @(negedge clk);
        compare_all();
        chk("wrap_reset_addr", w_addr, 32'hFFFF_FFF8);
        rst = 1'b1;

        // Four normal fetches after reset release
        cycle(0, 0, 0);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        chk("wrap_pc1", w_pc, 32'hFFFF_FFF8);
        cycle(0, 0, 0);
        chk("wrap_addr2", w_addr, 32'h0000_0000);
        chk("wrap_pc4_zero", w_pc4, 32'h0000_0000);
        chk("wrap_pc2", w_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("addr_after4", imem_addr, 32'd20);
        chk("count_after4", fetch_count, 32'd4);
        chk("lag_pc", if_id_pc, 32'd16);
        chk("or_inst", if_id_inst, 32'h0020_e233);

        // Mid-operation reset, then stall for 3 cycles at PC=12
        async_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            chk("stall_addr", imem_addr, 32'd12);
            chk("stall_ifid_pc", if_id_pc, 32'd8);
        end
        cycle(0, 0, 0);
        chk("resume_pc", if_id_pc, 32'd12);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("pc24", imem_addr, 32'd24);

        // Redirect overrides simultaneous stall
        cycle(1, 1, 32'h14);
        chk("redir_addr", imem_addr, 32'h14);
        chk("redir_bubble", {31'b0, if_id_valid}, 32'd0);
        chk("redir_count", fetch_count, 32'd5);
        cycle(0, 0, 0);
        chk("redir_target_pc", if_id_pc, 32'h14);
        chk("redir_target_valid", {31'b0, if_id_valid}, 32'd1);

        // Misaligned target is word aligned
        cycle(0, 1, 32'h23);
        chk("align_addr", imem_addr, 32'h20);

        // EBREAK at 28: halts only with FETCH_HALT_EN
        cycle(0, 1, 32'h1C);
        cycle(0, 0, 0);
        chk("ebreak_inst", if_id_inst, EBREAK);
        chk("ebreak_valid", {31'b0, if_id_valid}, 32'd1);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
`ifdef FETCH_HALT_EN
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_pc_hold", imem_addr, 32'h20);
        chk("halt_bubble", {31'b0, if_id_valid}, 32'd0);
`endif
        cycle(0, 1, 32'h8);
        chk("halt_exit_addr", imem_addr, 32'h8);
        cycle(0, 0, 0);
        chk("halt_exit_pc", if_id_pc, 32'h8);
        cycle(0, 1, 32'h1C);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        async_reset();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic st, rd;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            cycle(st, rd, $urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
